// File: rtl/vred_pkg.sv
// vred_pkg: shared states, SEW codes and beat-geometry helpers for the reduction sequencer
package vred_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LWAIT, FOLD, FWAIT, FINAL, FFWAIT, DONE} state_t;
  localparam logic [1:0] SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW64 = 2'd3;
  function automatic int epb(input logic [1:0] sew, input int w);
    return w / (8 << sew);
  endfunction
  function automatic int fold_count(input logic [1:0] sew, input int w);
    return $clog2(w) - 3 - int'(sew);
  endfunction
endpackage

// File: rtl/vred_tail_pad.sv
// vred_tail_pad: replaces lanes at or beyond the remainder with the reduction identity (0 or seed)
module vred_tail_pad
  import vred_pkg::*;
#(
  parameter int W = 64,
  parameter int SEW_WIDTH = 2,
  parameter int VL_WIDTH = 11
) (
  input  logic [W-1:0]         beat,
  input  logic [SEW_WIDTH-1:0] sew,
  input  logic [VL_WIDTH-1:0]  rem,
  input  logic                 is_sum,
  input  logic [W-1:0]         seed,
  output logic [W-1:0]         padded
);
  always_comb begin
    padded = beat;
    for (int i = 0; i < W / 8; i++)
      if (rem != '0 && VL_WIDTH'(i >> sew) >= rem)
        padded[8*i +: 8] = is_sum ? 8'h00 : seed[8*(i & ((1 << sew) - 1)) +: 8];
  end
endmodule

// File: rtl/vred_seq_ctrl.sv
// vred_seq_ctrl: beat-by-beat reduction sequencer with tree fold; RED_CYCLE_CNT_EN adds a latency counter
module vred_seq_ctrl
  import vred_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int OPSEL_WIDTH = 9,
  parameter int SEW_WIDTH = 2,
  parameter int VL_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEW_WIDTH-1:0]        sew,
  input  logic [OPSEL_WIDTH-1:0]      opSel,
  input  logic [VL_WIDTH-1:0]         vl,
  input  logic [REQ_DATA_WIDTH-1:0]   init_scalar,
  output logic                        busy,
  input  logic [REQ_DATA_WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [2*REQ_DATA_WIDTH-1:0] unit_vec0,
  output logic                        unit_en,
  output logic [SEW_WIDTH-1:0]        unit_sew,
  output logic [OPSEL_WIDTH-1:0]      unit_opSel,
  input  logic [RESP_DATA_WIDTH-1:0]  unit_out,
  output logic [REQ_DATA_WIDTH-1:0]   res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [15:0]                 red_cycles
);
  localparam int W = REQ_DATA_WIDTH;
  localparam int NB = W / 8;
  localparam int LGB = $clog2(NB);
  state_t state, state_n;
  logic [SEW_WIDTH-1:0] sew_r;
  logic [OPSEL_WIDTH-1:0] op_r;
  logic [VL_WIDTH-1:0] beats_left, rem_r;
  logic [W-1:0] seed_r, acc, padded, fold_a, fold_b;
  logic [3:0] lg;
  int lep;
  function automatic logic [W-1:0] rep(input logic [W-1:0] x, input logic [SEW_WIDTH-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = x[8*(i & ((1 << s) - 1)) +: 8];
    return r;
  endfunction
  function automatic logic [W-1:0] low(input logic [W-1:0] x, input logic [SEW_WIDTH-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) if ((i >> s) == 0) r[8*i +: 8] = x[8*i +: 8];
    return r;
  endfunction
  assign lep = LGB - int'(sew);
  vred_tail_pad #(.W(W), .SEW_WIDTH(SEW_WIDTH), .VL_WIDTH(VL_WIDTH)) u_pad (
    .beat(in_data), .sew(sew_r), .rem(beats_left == VL_WIDTH'(1) ? rem_r : '0),
    .is_sum(op_r[3]), .seed(seed_r), .padded(padded)
  );
  // lg is log2 of the live accumulator width in bytes; each fold pairs its upper and lower halves
  always_comb begin
    fold_a = '0;
    fold_b = '0;
    for (int i = 0; i < NB; i++) begin
      fold_a[8*i +: 8] = acc[8*(i & ((1 << (lg - 4'd1)) - 1)) +: 8];
      fold_b[8*i +: 8] = acc[8*((1 << (lg - 4'd1)) + (i & ((1 << (lg - 4'd1)) - 1))) +: 8];
    end
  end
  always_comb begin
    state_n = state;
    unit_en = 1'b0;
    unit_vec0 = '0;
    unique case (state)
      IDLE:   state_n = start ? (vl == '0 ? DONE : LOAD) : IDLE;
      LOAD: if (in_valid) begin
        unit_en = 1'b1;
        unit_vec0 = {padded, acc};
        state_n = LWAIT;
      end
      LWAIT:  state_n = beats_left != '0 ? LOAD : (lg == 4'(sew_r) ? FINAL : FOLD);
      FOLD: begin
        unit_en = 1'b1;
        unit_vec0 = {fold_b, fold_a};
        state_n = FWAIT;
      end
      FWAIT:  state_n = (lg - 4'd1) == 4'(sew_r) ? FINAL : FOLD;
      FINAL: begin
        unit_en = 1'b1;
        unit_vec0 = {acc, rep(seed_r, sew_r)};
        state_n = FFWAIT;
      end
      FFWAIT: state_n = DONE;
      DONE:   state_n = res_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sew_r <= '0;
      op_r <= '0;
      beats_left <= '0;
      rem_r <= '0;
      seed_r <= '0;
      acc <= '0;
      lg <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sew_r <= sew;
        op_r <= opSel;
        seed_r <= init_scalar;
        acc <= opSel[3] ? '0 : rep(init_scalar, sew);
        beats_left <= VL_WIDTH'((int'(vl) + (1 << lep) - 1) >> lep);
        rem_r <= VL_WIDTH'(int'(vl) & ((1 << lep) - 1));
        lg <= 4'(LGB);
        if (vl == '0) res_data <= low(init_scalar, sew);
      end
      if (state == LOAD && in_valid) beats_left <= beats_left - VL_WIDTH'(1);
      if (state == LWAIT || state == FWAIT) acc <= unit_out[W-1:0];
      if (state == FWAIT) lg <= lg - 4'd1;
      if (state == FFWAIT) res_data <= low(unit_out[W-1:0], sew_r);
    end
  end
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign res_valid = state == DONE;
  assign unit_sew = sew_r;
  assign unit_opSel = op_r;
`ifdef RED_CYCLE_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (state == IDLE && start) cnt <= 16'd1;
    else if (busy && state != DONE && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign red_cycles = cnt;
`else
  assign red_cycles = '0;
`endif
endmodule
